// File: rtl/dbus_map_pkg.sv
// Shared address map, status bit layout and region decode for dbus_responder.
package dbus_map_pkg;

    localparam logic [15:0] RAM_LIMIT   = 16'h8000;
    localparam logic [15:0] ADDR_GPIO   = 16'h8000;
    localparam logic [15:0] ADDR_CYCLE  = 16'h8004;
    localparam logic [15:0] ADDR_TXDATA = 16'h8008;
    localparam logic [15:0] ADDR_STATUS = 16'h800C;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_GPIO,
        REG_CYCLE,
        REG_TXDATA,
        REG_STATUS,
        REG_NONE
    } region_e;

    // Byte offset bits are not part of the decode; callers pass the word address.
    function automatic region_e decode_region(input logic [15:2] word);
        logic [15:0] byte_addr;
        byte_addr = {word, 2'b00};
        if (byte_addr < RAM_LIMIT) return REG_RAM;
        case (byte_addr)
            ADDR_GPIO:   return REG_GPIO;
            ADDR_CYCLE:  return REG_CYCLE;
            ADDR_TXDATA: return REG_TXDATA;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dbus_txfifo.sv
// Byte FIFO for the TX path; a push when full is accepted only if a pop frees a slot the same cycle.
module dbus_txfifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic       drop,
    output logic [3:0] count,
    output logic [7:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 4'd0);
    assign full    = (count == 4'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave: RAM, GPIO, free-running cycle counter and TX FIFO behind a 16-bit address map.
// The TX FIFO is built only when DBUS_TXFIFO_EN is defined.
module dbus_responder
    import dbus_map_pkg::*;
#(
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dbus_addr,
    input  logic [31:0] dbus_write,
    input  logic        dbus_wen,
    output logic [31:0] dbus_read,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]     ram [RAM_WORDS];
    logic [31:0]     cycle_cnt;
    logic [31:0]     status;
    logic [31:0]     rdata;
    logic [12:0]     word_idx;
    logic [RAM_AW-1:0] ram_sel;
    region_e         region;
    logic            ram_hit;
    logic            wr_gpio;
    logic            wr_tx;
    logic            wr_status;
    logic            unused_addr;

    assign word_idx    = dbus_addr[14:2];
    assign ram_sel     = word_idx[RAM_AW-1:0];
    assign region      = decode_region(dbus_addr[15:2]);
    assign ram_hit     = (region == REG_RAM) && (int'(word_idx) < RAM_WORDS);
    assign wr_gpio     = dbus_wen && (region == REG_GPIO);
    assign wr_tx       = dbus_wen && (region == REG_TXDATA);
    assign wr_status   = dbus_wen && (region == REG_STATUS);
    assign unused_addr = ^dbus_addr[1:0];

    always_ff @(posedge clk) begin
        if (dbus_wen && ram_hit) ram[ram_sel] <= dbus_write;
    end

    always_comb begin
        rdata = '0;
        if (!dbus_wen) begin
            case (region)
                REG_RAM:    if (ram_hit) rdata = ram[ram_sel];
                REG_GPIO:   rdata = gpio_out;
                REG_CYCLE:  rdata = cycle_cnt;
                REG_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_read <= '0;
            gpio_out  <= '0;
            cycle_cnt <= '0;
        end else begin
            dbus_read <= rdata;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (wr_gpio) gpio_out <= dbus_write;
        end
    end

`ifdef DBUS_TXFIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;
    logic [3:0] fifo_count;
    logic [7:0] fifo_head;
    logic       overflow;

    dbus_txfifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_txfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_tx),
        .push_data (dbus_write[7:0]),
        .pop       (tx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // A dropped push outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
        else if (wr_status && dbus_write[STAT_OVF])
            overflow <= 1'b0;
    end

    always_comb begin
        status                                   = '0;
        status[STAT_COUNT_LSB +: 4]              = fifo_count;
        status[STAT_OVF]                         = overflow;
        status[STAT_FULL]                        = fifo_full;
        status[STAT_EMPTY]                       = fifo_empty;
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;
`else
    logic unused_fifo;

    assign unused_fifo = ^{tx_ready, wr_tx, wr_status};
    assign status      = 32'h0000_0001;
    assign tx_valid    = 1'b0;
    assign tx_data     = '0;
`endif

endmodule

// File: tb/tb_dbus_responder.sv
// Randomised self-checking bench for dbus_responder against a queue/array model of the bus map.
module tb_dbus_responder;

    localparam int RAM_WORDS  = 4096;
    localparam int FIFO_DEPTH = 8;
`ifdef DBUS_TXFIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dbus_addr;
    logic [31:0] dbus_write;
    logic        dbus_wen;
    logic [31:0] dbus_read;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_m [int];
    logic [31:0] gpio_m;
    logic [31:0] cnt_m;
    logic [7:0]  q_m [$];
    logic        ovf_m;

    dbus_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dbus_addr  (dbus_addr),
        .dbus_write (dbus_write),
        .dbus_wen   (dbus_wen),
        .dbus_read  (dbus_read),
        .gpio_out   (gpio_out),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [15:0] wa);
        int idx;
        int n;
        idx = int'(wa[14:2]);
        n   = q_m.size();
        if (wa < 16'h8000)
            return (idx < RAM_WORDS && ram_m.exists(idx)) ? ram_m[idx] : 32'h0;
        case (wa)
            16'h8000: return gpio_m;
            16'h8004: return cnt_m;
            16'h800C: return FIFO_ON ? {24'h0, 4'(n), 1'b0, ovf_m, n == FIFO_DEPTH, n == 0}
                                     : 32'h1;
            default:  return 32'h0;
        endcase
    endfunction

    // One bus cycle: predict the read, advance the model, then clock the DUT.
    task automatic drive(input logic [15:0] a, input logic w, input logic [31:0] d,
                         input logic rdy, output logic [31:0] exp);
        logic [15:0] wa;
        int idx;
        wa  = {a[15:2], 2'b00};
        idx = int'(wa[14:2]);
        exp = w ? 32'h0 : model_read(wa);
        if (w && wa < 16'h8000 && idx < RAM_WORDS) ram_m[idx] = d;
        if (w && wa == 16'h8000) gpio_m = d;
        if (FIFO_ON) begin
            if (q_m.size() > 0 && rdy) void'(q_m.pop_front());
            if (w && wa == 16'h8008) begin
                if (q_m.size() < FIFO_DEPTH) q_m.push_back(d[7:0]);
                else ovf_m = 1'b1;
            end else if (w && wa == 16'h800C && d[2]) begin
                ovf_m = 1'b0;
            end
        end
        cnt_m = cnt_m + 32'd1;
        dbus_addr  = a;
        dbus_wen   = w;
        dbus_write = d;
        tx_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic [31:0] e;
        drive(16'h800C, 1'b1, 32'h4, 1'b1, e);
        for (int i = 0; i <= FIFO_DEPTH; i++) drive(16'h800C, 1'b0, 32'h0, 1'b1, e);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        rst_n = 1'b0; dbus_addr = 16'h8004; dbus_write = '0; dbus_wen = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dbus_read !== 32'h0 || gpio_out !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_outputs got read=%h gpio=%h valid=%b data=%h exp all 0",
                     dbus_read, gpio_out, tx_valid, tx_data);
        end
        rst_n = 1'b1;
        gpio_m = '0; cnt_m = '0; ovf_m = 1'b0; q_m.delete();
        drive(16'h800C, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== e) begin
            errors++; $display("FAIL reset_status got %h exp %h", dbus_read, e);
        end
        drive(16'h8004, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h1) begin
            errors++; $display("FAIL reset_counter_start got %h exp %h", dbus_read, 32'h1);
        end
    endtask

    task automatic test_ram();
        logic [31:0] e;
        drive(16'h0010, 1'b1, 32'hDEAD_BEEF, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL ram_write_cycle_read got %h exp %h", dbus_read, 32'h0);
        end
        drive(16'h0010, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_readback got %h exp %h", dbus_read, 32'hDEAD_BEEF);
        end
        drive(16'h0013, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== e) begin
            errors++; $display("FAIL ram_low_bits got %h exp %h", dbus_read, e);
        end
        drive(16'h3FFC, 1'b1, 32'h1234_5678, 1'b0, e);
        drive(16'h3FFC, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_last_word got %h exp %h", dbus_read, 32'h1234_5678);
        end
    endtask

    task automatic test_counter();
        logic [31:0] e;
        logic [31:0] first;
        drive(16'h8004, 1'b0, 32'h0, 1'b0, e);
        first = dbus_read;
        checks++;
        if (dbus_read !== e) begin
            errors++; $display("FAIL counter_a got %h exp %h", dbus_read, e);
        end
        drive(16'h8004, 1'b1, 32'hFFFF_0000, 1'b0, e);
        drive(16'h8004, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== first + 32'd2 || dbus_read !== e) begin
            errors++; $display("FAIL counter_step got %h exp %h", dbus_read, first + 32'd2);
        end
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cnt_m = 32'hFFFF_FFFF;
        drive(16'h8004, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL counter_max got %h exp %h", dbus_read, 32'hFFFF_FFFF);
        end
        drive(16'h8004, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL counter_wrap got %h exp %h", dbus_read, 32'h0);
        end
    endtask

    task automatic test_map();
        logic [31:0] e;
        drive(16'h9000, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL unmapped_9000 got %h exp %h", dbus_read, 32'h0);
        end
        drive(16'h7FFC, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL unmapped_7ffc got %h exp %h", dbus_read, 32'h0);
        end
        drive(16'h4000, 1'b1, 32'hCAFE_F00D, 1'b0, e);
        drive(16'h4000, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL ram_beyond_depth got %h exp %h", dbus_read, 32'h0);
        end
        drive(16'h8000, 1'b1, 32'h55, 1'b0, e);
        checks++;
        if (gpio_out !== 32'h55) begin
            errors++; $display("FAIL gpio_out got %h exp %h", gpio_out, 32'h55);
        end
        drive(16'h8008, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h0) begin
            errors++; $display("FAIL txdata_read got %h exp %h", dbus_read, 32'h0);
        end
        drive(16'h8000, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'h55) begin
            errors++; $display("FAIL gpio_read got %h exp %h", dbus_read, 32'h55);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] e;
        logic [7:0]  first;
        first = 8'($urandom);
        drive(16'h8008, 1'b1, {24'h0, first}, 1'b0, e);
        for (int i = 1; i < 9; i++) drive(16'h8008, 1'b1, $urandom, 1'b0, e);
        drive(16'h800C, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== (FIFO_ON ? 32'h86 : 32'h1)) begin
            errors++; $display("FAIL status_overflow got %h exp %h", dbus_read, FIFO_ON ? 32'h86 : 32'h1);
        end
        checks++;
        if (tx_data !== (FIFO_ON ? first : 8'h0) || tx_valid !== FIFO_ON) begin
            errors++; $display("FAIL head_byte got %h/%b exp %h/%b", tx_data, tx_valid,
                               FIFO_ON ? first : 8'h0, FIFO_ON);
        end
        drive(16'h800C, 1'b1, 32'h4, 1'b0, e);
        drive(16'h800C, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== (FIFO_ON ? 32'h82 : 32'h1)) begin
            errors++; $display("FAIL status_clear got %h exp %h", dbus_read, FIFO_ON ? 32'h82 : 32'h1);
        end
        for (int i = 0; i < 9; i++) begin
            drive(16'h800C, 1'b0, 32'h0, 1'b1, e);
            checks++;
            if (tx_valid !== (q_m.size() > 0) || tx_data !== (q_m.size() > 0 ? q_m[0] : 8'h0)) begin
                errors++; $display("FAIL drain_order got %h/%b exp %h/%b", tx_data, tx_valid,
                                   q_m.size() > 0 ? q_m[0] : 8'h0, q_m.size() > 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < FIFO_DEPTH; i++) drive(16'h8008, 1'b1, 32'h40 + i, 1'b0, e);
        drive(16'h8008, 1'b1, 32'hA5, 1'b1, e);
        drive(16'h800C, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== (FIFO_ON ? 32'h82 : 32'h1)) begin
            errors++; $display("FAIL full_push_pop got %h exp %h", dbus_read, FIFO_ON ? 32'h82 : 32'h1);
        end
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            drive(16'h8004, 1'b0, 32'h0, 1'b1, e);
            checks++;
            if (tx_valid !== (q_m.size() > 0) || tx_data !== (q_m.size() > 0 ? q_m[0] : 8'h0)) begin
                errors++; $display("FAIL full_drain_order got %h/%b exp %h/%b", tx_data, tx_valid,
                                   q_m.size() > 0 ? q_m[0] : 8'h0, q_m.size() > 0);
            end
        end
        drive(16'h8008, 1'b1, 32'h77, 1'b1, e);
        checks++;
        if (tx_valid !== FIFO_ON || tx_data !== (FIFO_ON ? 8'h77 : 8'h0)) begin
            errors++; $display("FAIL empty_push_no_pop got %h/%b exp %h/%b", tx_data, tx_valid,
                               FIFO_ON ? 8'h77 : 8'h0, FIFO_ON);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [15:0] a;
        logic [15:0] pool [8];
        logic        w;
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i == 7) ? 16'h3FFC : 16'(16'h0100 + 4 * i);
            drive(pool[i], 1'b1, $urandom, 1'b0, e);
        end
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0:       a = pool[$urandom_range(0, 7)];
                1:       a = 16'h8000;
                2:       a = 16'h8004;
                3, 4:    a = 16'h8008;
                5:       a = 16'h800C;
                default: a = 16'h9000 + 16'($urandom_range(0, 255));
            endcase
            a = {a[15:2], 2'($urandom)};
            w = ($urandom_range(0, 2) == 0);
            drive(a, w, $urandom, 1'($urandom), e);
            checks++;
            if (dbus_read !== e || gpio_out !== gpio_m || tx_valid !== (q_m.size() > 0)
                || tx_data !== (q_m.size() > 0 ? q_m[0] : 8'h0)) begin
                errors++;
                $display("FAIL random_cycle_%0d got read=%h gpio=%h tx=%h/%b exp read=%h gpio=%h tx=%h/%b",
                         i, dbus_read, gpio_out, tx_data, tx_valid, e, gpio_m,
                         q_m.size() > 0 ? q_m[0] : 8'h0, q_m.size() > 0);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) drive(16'h8008, 1'b1, 32'h10 + i, 1'b0, e);
        drive(16'h8000, 1'b1, 32'h99, 1'b0, e);
        dbus_wen = 1'b0;
        dbus_addr = 16'h8000;
        tx_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h0 || gpio_out !== 32'h0 || dbus_read !== 32'h0) begin
            errors++; $display("FAIL async_reset got valid=%b data=%h gpio=%h read=%h exp 0",
                               tx_valid, tx_data, gpio_out, dbus_read);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gpio_m = '0; cnt_m = '0; ovf_m = 1'b0; q_m.delete();
        drive(16'h800C, 1'b0, 32'h0, 1'b1, e);
        checks++;
        if (dbus_read !== 32'h1 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL status_after_reset got %h/%b exp %h/0", dbus_read, tx_valid, 32'h1);
        end
        drive(16'h0010, 1'b0, 32'h0, 1'b0, e);
        checks++;
        if (dbus_read !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_kept_over_reset got %h exp %h", dbus_read, 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_counter();
        test_map();
        test_fifo_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096, giving on-chip RAM depth in 32-bit words; legal range 1..8192.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving TX FIFO depth; power of two, 2..8.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock, all state on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port dbus_addr, input, 16, byte address from the CPU, driven every cycle.
REQ-006 SHALL have port dbus_write, input, 32, write data.
REQ-007 SHALL have port dbus_wen, input, 1, write strobe; 0 means read.
REQ-008 SHALL have port dbus_read, output, 32, read data, registered.
REQ-009 SHALL have port gpio_out, output, 32, GPIO output register.
REQ-010 SHALL have port tx_data, output, 8, FIFO head byte.
REQ-011 SHALL have port tx_valid, output, 1, FIFO non-empty.
REQ-012 SHALL have port tx_ready, input, 1, downstream accepts tx_data.

Function
REQ-013 SHALL decode the map: 0x0000-0x7FFF RAM; 0x8000 GPIO (RW); 0x8004 cycle counter (RO); 0x8008 TX data (WO); 0x800C status (RW1C); all else unmapped.
REQ-014 SHALL ignore dbus_addr[1:0]; RAM word index is dbus_addr[14:2], and indices >= RAM_WORDS are unmapped.
REQ-015 SHALL, for a cycle with dbus_wen=0, present the addressed word on dbus_read after the next posedge (1-cycle latency); unmapped, TX data, and any dbus_wen=1 cycle return 0.
REQ-016 SHALL make reads side-effect free, since the CPU presents an address every cycle.
REQ-017 SHALL commit writes at the posedge ending the dbus_wen=1 cycle; a read of the same address in the next cycle returns the new value.
REQ-018 SHALL ignore writes to unmapped addresses and to 0x8004.
REQ-019 SHALL increment the cycle counter by 1 every cycle, 32-bit, wrapping 0xFFFFFFFF to 0.
REQ-020 SHALL push dbus_write[7:0] into the TX FIFO on a write to 0x8008 when not full; a push when full is dropped and sets sticky overflow.
REQ-021 SHALL drive tx_valid = FIFO not empty and tx_data = head byte; pop occurs on posedge with tx_valid && tx_ready.
REQ-022 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-023 SHALL, on a simultaneous push and pop, perform both, including when full (no overflow) and when it holds exactly one entry; an empty FIFO with a push is not popped that cycle.
REQ-024 SHALL read status as {24'b0, count[3:0], 1'b0, overflow, full, empty}.
REQ-025 SHALL clear overflow on a write to 0x800C with dbus_write[2]=1; a same-cycle overflow event takes priority.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force dbus_read=0, gpio_out=0, counter=0, FIFO empty, overflow=0, tx_valid=0, tx_data=0.
REQ-028 SHALL leave RAM contents unreset; a reset mid-transfer discards queued FIFO bytes.

Configuration
REQ-029 SHALL gate the TX FIFO with macro DBUS_TXFIFO_EN: when defined, REQ-020..026 apply.
REQ-030 SHALL, when DBUS_TXFIFO_EN is undefined, omit the FIFO, drop 0x8008 writes, read status as 0x00000001, and tie tx_valid=0 and tx_data=0.

Structure
REQ-031 SHALL place address constants (ADDR_GPIO, ADDR_CYCLE, ADDR_TXDATA, ADDR_STATUS, RAM_LIMIT) and status bit indices in shared package dbus_map_pkg.
REQ-032 SHALL implement the FIFO as sub-module dbus_txfifo (push/pop/full/empty/count); decode, RAM, GPIO, counter in top.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to 0x0010, then read 0x0010 -> dbus_read=0xDEADBEEF one cycle after the read address.
REQ-034 SHALL cover: read 0x8004 on two consecutive cycles -> values differ by exactly 1; force counter 0xFFFFFFFF -> next 0.
REQ-035 SHALL cover: 9 writes to 0x8008 with tx_ready=0 (depth 8) -> status 0x00000086, tx_data=first byte; write 0x4 to 0x800C -> 0x00000082.
REQ-036 SHALL cover: FIFO full, tx_ready=1, push same cycle -> count stays 8, overflow 0, bytes emerge in order.
REQ-037 SHALL cover: read 0x9000 and 0x7FFC with RAM_WORDS=4096 -> 0; write 0x55 to 0x8000 -> gpio_out=0x55 next cycle.
REQ-038 SHALL cover: assert rst_n=0 mid-drain with 3 queued bytes -> tx_valid=0 immediately, status 0x00000001 after release.
